// File: rtl/score_display_arbiter.sv
// Display owner arbiter: routes the live score view or one of two latched
// message banners to the seven-segment scan driver, with a score blink option.
module score_display_arbiter #(
  parameter logic [26:0] HOLD_TICKS  = 27'd100_000_000,
  parameter logic [26:0] BLINK_TICKS = 27'd25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] score_seg,
  input  logic [7:0]  score_en,
  input  logic        blink_en,
  input  logic [1:0]  msg_req,
  input  logic [55:0] msg_seg0,
  input  logic [55:0] msg_seg1,
  output logic [1:0]  msg_ack,
  output logic [1:0]  owner,
  output logic [55:0] seg_out,
  output logic [7:0]  an_out
);

  typedef enum logic [1:0] {
    SCORE = 2'd0,
    MSG0  = 2'd1,
    MSG1  = 2'd2
  } state_t;

  state_t      state;
  logic [26:0] timer;
  logic [26:0] blink_cnt;
  logic        phase;
  logic [55:0] msg_reg;

  // Digit enables for the score view; blanked during the off half of a blink.
  function automatic logic [7:0] score_an(input logic [7:0] en,
                                          input logic       blink,
                                          input logic       ph);
    score_an = blink ? (en & {8{ph}}) : en;
  endfunction

  assign owner = state;

  // Free-running blink phase generator, independent of who owns the display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == BLINK_TICKS - 27'd1) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 27'd1;
    end
  end

  // Ownership FSM with registered acks and display outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SCORE;
      timer   <= '0;
      msg_reg <= '0;
      msg_ack <= 2'b00;
      seg_out <= '0;
      an_out  <= '0;
    end else begin
      msg_ack <= 2'b00;
      case (state)
        SCORE: begin
          if (msg_req[1]) begin
            state   <= MSG1;
            msg_ack <= 2'b10;
            msg_reg <= msg_seg1;
            seg_out <= msg_seg1;
            an_out  <= 8'hFF;
            timer   <= HOLD_TICKS - 27'd1;
          end else if (msg_req[0]) begin
            state   <= MSG0;
            msg_ack <= 2'b01;
            msg_reg <= msg_seg0;
            seg_out <= msg_seg0;
            an_out  <= 8'hFF;
            timer   <= HOLD_TICKS - 27'd1;
          end else begin
            seg_out <= score_seg;
            an_out  <= score_an(score_en, blink_en, phase);
          end
        end
        MSG0: begin
          // The game-over banner may cut the point banner short at any time.
          if (msg_req[1]) begin
            state   <= MSG1;
            msg_ack <= 2'b10;
            msg_reg <= msg_seg1;
            seg_out <= msg_seg1;
            an_out  <= 8'hFF;
            timer   <= HOLD_TICKS - 27'd1;
          end else if (timer == 27'd0) begin
            state   <= SCORE;
            seg_out <= score_seg;
            an_out  <= score_an(score_en, blink_en, phase);
          end else begin
            timer   <= timer - 27'd1;
            seg_out <= msg_reg;
            an_out  <= 8'hFF;
          end
        end
        MSG1: begin
          if (timer == 27'd0) begin
            state   <= SCORE;
            seg_out <= score_seg;
            an_out  <= score_an(score_en, blink_en, phase);
          end else begin
            timer   <= timer - 27'd1;
            seg_out <= msg_reg;
            an_out  <= 8'hFF;
          end
        end
        default: begin
          state   <= SCORE;
          seg_out <= score_seg;
          an_out  <= score_an(score_en, blink_en, phase);
        end
      endcase
    end
  end

endmodule
